// File: rtl/mem_dump_unit.sv
// -----------------------------------------------------------------------------
// mem_dump_unit
//
// Walks a contiguous range of data-memory words after a start pulse and
// streams each 16-bit word to a byte-wide UART transmitter, high byte first.
// Used to dump RAM contents after a program run.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset, overrides everything
//   start       one-cycle dump request, only honoured in IDLE
//   start_addr  first word address, captured on an accepted start
//   word_count  number of words to dump (0..2^AB), captured on an accepted start
//   RdRam       read strobe to data memory (READ and LATCH only)
//   WrRam       write strobe to data memory, never asserted
//   Addr        address to data memory, holds its last value outside reads
//   mem_data    data-memory output word
//   tx_start    one-cycle pulse, tx_data valid
//   tx_data     byte to transmit, held until the next byte is launched
//   tx_done     one-cycle pulse from transmitter, byte finished
//   busy        high from accepted start until the DONE state is left
//   done        one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module mem_dump_unit #(
    parameter int AB = 11,
    parameter int DB = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AB-1:0] start_addr,
    input  logic [AB:0]   word_count,
    output logic          RdRam,
    output logic          WrRam,
    output logic [AB-1:0] Addr,
    input  logic [DB-1:0] mem_data,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_READ    = 4'd1,
        S_LATCH   = 4'd2,
        S_SEND_HI = 4'd3,
        S_WAIT_HI = 4'd4,
        S_SEND_LO = 4'd5,
        S_WAIT_LO = 4'd6,
        S_NEXT    = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    localparam logic [AB-1:0] ADDR_ZERO = {AB{1'b0}};
    localparam logic [AB-1:0] ADDR_ONE  = {{(AB-1){1'b0}}, 1'b1};
    localparam logic [AB:0]   CNT_ZERO  = {(AB+1){1'b0}};
    localparam logic [AB:0]   CNT_ONE   = {{AB{1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_s;
    logic [AB-1:0] addr_r;
    logic [AB-1:0] addr_s;
    logic [AB:0]   count_r;
    logic [AB:0]   count_s;
    logic [DB-1:0] word_r;

    // Output registers and their next values
    logic          rd_ram_r;
    logic          rd_ram_s;
    logic [AB-1:0] addr_out_r;
    logic [AB-1:0] addr_out_s;
    logic          tx_start_r;
    logic          tx_start_s;
    logic [7:0]    tx_data_r;
    logic [7:0]    tx_data_s;
    logic          busy_r;
    logic          busy_s;
    logic          done_r;
    logic          done_s;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        count_s = count_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    addr_s  = start_addr;
                    count_s = word_count;
                    if (word_count == CNT_ZERO) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ:    state_s = S_LATCH;
            S_LATCH:   state_s = S_SEND_HI;
            S_SEND_HI: state_s = S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_done) begin
                    state_s = S_SEND_LO;
                end else begin
                    state_s = S_WAIT_HI;
                end
            end
            S_SEND_LO: state_s = S_WAIT_LO;
            S_WAIT_LO: begin
                if (tx_done) begin
                    state_s = S_NEXT;
                end else begin
                    state_s = S_WAIT_LO;
                end
            end
            S_NEXT: begin
                // Address wraps naturally at 2^AB
                addr_s  = addr_r + ADDR_ONE;
                count_s = count_r - CNT_ONE;
                if (count_s == CNT_ZERO) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase

        // Outputs are registered from the upcoming state so they line up
        // with the state they belong to without a combinational path out.
        rd_ram_s   = (state_s == S_READ) || (state_s == S_LATCH);
        tx_start_s = (state_s == S_SEND_HI) || (state_s == S_SEND_LO);
        busy_s     = (state_s != S_IDLE);
        done_s     = (state_s == S_DONE);

        if (state_s == S_READ) begin
            addr_out_s = addr_s;
        end else begin
            addr_out_s = addr_out_r;
        end

        // Entering SEND_HI happens from LATCH, before word_r is loaded, so
        // the high byte is taken straight from the memory bus.
        case (state_s)
            S_SEND_HI: tx_data_s = mem_data[15:8];
            S_SEND_LO: tx_data_s = word_r[7:0];
            default:   tx_data_s = tx_data_r;
        endcase
    end

    // State, address, count and word registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            addr_r  <= ADDR_ZERO;
            count_r <= CNT_ZERO;
            word_r  <= {DB{1'b0}};
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            count_r <= count_s;
            if (state_r == S_LATCH) begin
                word_r <= mem_data;
            end else begin
                word_r <= word_r;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ram_r   <= 1'b0;
            addr_out_r <= ADDR_ZERO;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_ram_r   <= rd_ram_s;
            addr_out_r <= addr_out_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign RdRam    = rd_ram_r;
    assign WrRam    = 1'b0;
    assign Addr     = addr_out_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mem_dump_unit.sv
module tb_mem_dump_unit;

    localparam int AB = 11;
    localparam int DB = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AB-1:0] start_addr;
    logic [AB:0]   word_count;
    logic          RdRam;
    logic          WrRam;
    logic [AB-1:0] Addr;
    logic [DB-1:0] mem_data;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;
    logic          done;

    logic          tx_done_m;
    logic          spurious;
    int            tx_delay;
    int            tx_cnt;

    logic [DB-1:0] mem [0:(1<<AB)-1];

    logic [7:0]    exp_bytes[$];
    logic [AB-1:0] exp_addrs[$];

    int checks;
    int failures;
    int done_cnt;
    int txs_cnt;
    int rd_cnt;
    int busy_cnt;

    logic          rd_prev;
    logic [AB-1:0] addr_prev;
    logic          done_prev;
    logic          have_held;
    logic [7:0]    held;

    mem_dump_unit #(.AB(AB), .DB(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .RdRam      (RdRam),
        .WrRam      (WrRam),
        .Addr       (Addr),
        .mem_data   (mem_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_done = tx_done_m | spurious;

    // Synchronous-read memory: data appears one edge after the address
    always @(posedge clk) mem_data <= mem[Addr];

    // Transmitter model: tx_done pulse tx_delay cycles after tx_start
    always @(negedge clk) begin
        if (reset) begin
            tx_cnt    = 0;
            tx_done_m = 1'b0;
        end else begin
            tx_done_m = 1'b0;
            if (tx_start) begin
                tx_cnt = tx_delay;
            end else if (tx_cnt != 0) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0) tx_done_m = 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor / scoreboard consumer
    always @(negedge clk) begin
        check_val("wrram_zero", {31'd0, WrRam}, 32'd0);
        if (reset) begin
            have_held = 1'b0;
            rd_prev   = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (RdRam) rd_cnt = rd_cnt + 1;

            if (RdRam && !rd_prev) begin
                check_val("addr_q_nonempty", {31'd0, exp_addrs.size() != 0}, 32'd1);
                if (exp_addrs.size() != 0) check_val("read_addr", {21'd0, Addr}, {21'd0, exp_addrs.pop_front()});
            end else if (RdRam && rd_prev) begin
                check_val("addr_hold", {21'd0, Addr}, {21'd0, addr_prev});
            end

            if (tx_start) begin
                txs_cnt = txs_cnt + 1;
                check_val("byte_q_nonempty", {31'd0, exp_bytes.size() != 0}, 32'd1);
                if (exp_bytes.size() != 0) check_val("tx_byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
                held      = tx_data;
                have_held = 1'b1;
            end else if (have_held) begin
                check_val("tx_hold", {24'd0, tx_data}, {24'd0, held});
            end

            if (done) begin
                done_cnt = done_cnt + 1;
                check_val("busy_at_done", {31'd0, busy}, 32'd1);
            end
            if (done_prev) check_val("busy_fall", {31'd0, busy}, 32'd0);

            rd_prev   = RdRam;
            addr_prev = Addr;
            done_prev = done;
        end
    end

    task automatic start_dump(input int sa, input int wc);
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        @(negedge clk);
        for (int w = 0; w < wc; w++) begin
            a = AB'((sa + w) % (1 << AB));
            d = mem[a];
            exp_addrs.push_back(a);
            exp_bytes.push_back(d[15:8]);
            exp_bytes.push_back(d[7:0]);
        end
        start_addr = AB'(sa);
        word_count = (AB+1)'(wc);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic settle_and_check(input string tag, input int d0);
        repeat (10) @(negedge clk);
        check_val({tag, "_done_once"}, done_cnt - d0, 32'd1);
        check_val({tag, "_bytes_left"}, exp_bytes.size(), 32'd0);
        check_val({tag, "_addrs_left"}, exp_addrs.size(), 32'd0);
    endtask

    task automatic wait_txs(input int target, input int budget);
        int n;
        n = 0;
        while (txs_cnt < target && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check_val("txs_reached", {31'd0, txs_cnt >= target}, 32'd1);
    endtask

    initial begin
        int d0, t0, r0, b0;
        checks = 0; failures = 0;
        done_cnt = 0; txs_cnt = 0; rd_cnt = 0; busy_cnt = 0;
        rd_prev = 1'b0; addr_prev = '0; done_prev = 1'b0; have_held = 1'b0; held = 8'h00;
        tx_delay = 3; tx_cnt = 0; tx_done_m = 1'b0; spurious = 1'b0;
        reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
        for (int i = 0; i < (1 << AB); i++) mem[i] = DB'(i);

        repeat (3) @(negedge clk);
        check_val("rst_rdram", {31'd0, RdRam}, 32'd0);
        check_val("rst_addr", {21'd0, Addr}, 32'd0);
        check_val("rst_txstart", {31'd0, tx_start}, 32'd0);
        check_val("rst_txdata", {24'd0, tx_data}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // 1: basic two-word dump
        d0 = done_cnt;
        start_dump(5, 2);
        wait_done(200);
        settle_and_check("t1", d0);

        // 2: address wrap-around
        d0 = done_cnt;
        start_dump(2047, 2);
        wait_done(200);
        settle_and_check("t2", d0);

        // 3: zero-length dump
        d0 = done_cnt; t0 = txs_cnt; r0 = rd_cnt; b0 = busy_cnt;
        start_dump(9, 0);
        check_val("t3_done_next", {31'd0, done}, 32'd1);
        check_val("t3_busy_next", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_val("t3_done_off", {31'd0, done}, 32'd0);
        check_val("t3_busy_off", {31'd0, busy}, 32'd0);
        settle_and_check("t3", d0);
        check_val("t3_no_tx", txs_cnt - t0, 32'd0);
        check_val("t3_no_rd", rd_cnt - r0, 32'd0);
        check_val("t3_busy_cycles", busy_cnt - b0, 32'd1);

        // 4: second start during WAIT_LO of word 0 is ignored
        d0 = done_cnt; t0 = txs_cnt;
        start_dump(5, 2);
        wait_txs(t0 + 2, 50);
        @(negedge clk);
        start_addr = 11'd100; word_count = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        settle_and_check("t4", d0);
        check_val("t4_tx_count", txs_cnt - t0, 32'd4);

        // 5: reset in WAIT_HI of word 1, then a fresh one-word dump
        t0 = txs_cnt;
        start_dump(5, 2);
        wait_txs(t0 + 3, 80);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("t5_rdram", {31'd0, RdRam}, 32'd0);
        check_val("t5_addr", {21'd0, Addr}, 32'd0);
        check_val("t5_txstart", {31'd0, tx_start}, 32'd0);
        check_val("t5_txdata", {24'd0, tx_data}, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        check_val("t5_done", {31'd0, done}, 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
        reset = 1'b0;
        d0 = done_cnt; t0 = txs_cnt;
        start_dump(0, 1);
        wait_done(200);
        settle_and_check("t5", d0);
        check_val("t5_tx_count", txs_cnt - t0, 32'd2);

        // 6: stalled transmitter plus spurious tx_done during READ
        d0 = done_cnt;
        tx_delay = 100;
        start_dump(10, 2);
        check_val("t6_in_read", {31'd0, RdRam}, 32'd1);
        spurious = 1'b1;
        @(negedge clk);
        spurious = 1'b0;
        wait_done(2000);
        settle_and_check("t6", d0);
        tx_delay = 3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
